// File: rtl/prewish5k_multiblinky.sv
// -----------------------------------------------------------------------------
// prewish5k_multiblinky
//
// Multi-channel LED pattern blinker with a small Wishbone-style slave port.
// Each of NCH channels holds a MASK_BITS-wide pattern that is shifted out
// MSB-first, one bit per divider tick, onto its o_led bit. A channel runs in
// REPEAT mode (pattern rotates forever) or ONESHOT mode (pattern shifts out
// once with zero fill, then the LED stays dark).
//
// Optional build macro:
//   MULTIBLINKY_READBACK_EN  - when defined, reads return the channel's
//                              working pattern (MASK) or {DONE, ONESHOT}
//                              (CTRL). When undefined, DAT_O is tied to 0
//                              and no read mux exists; reads are still ACKed.
//
// Parameters:
//   NCH             - number of blink channels (1..16)
//   MASK_BITS       - pattern length and data bus width (2..32)
//   SYSCLK_DIV_BITS - width of the shared free-running divider
//
// Ports:
//   CLK_I    in   clock, all logic on the rising edge
//   RST_I    in   asynchronous active-high reset
//   STB_I    in   bus strobe (slave selected)
//   WE_I     in   1 = write, 0 = read
//   ADR_I    in   [0] 0 = MASK, 1 = CTRL; upper bits = channel index
//   DAT_I    in   write data
//   DAT_O    out  registered read data
//   ACK_O    out  registered one-cycle acknowledge
//   o_alive  out  divider MSB, slow "alive" square wave
//   o_led    out  registered LED drive, bit n = channel n, active high
//
// Handshake: an access is performed in the cycle where STB_I=1 and ACK_O=0.
// ACK_O is registered as STB_I & ~ACK_O, so it rises the cycle after the
// access and drops one cycle later. A strobe held high therefore produces
// one access every two cycles (ACK alternates high/low). Read data is
// registered on the same edge that raises ACK_O and is valid while ACK_O=1;
// it then holds until the next read.
// -----------------------------------------------------------------------------
module prewish5k_multiblinky #(
  parameter int NCH             = 4,
  parameter int MASK_BITS       = 8,
  parameter int SYSCLK_DIV_BITS = 22
) (
  input  logic                   CLK_I,
  input  logic                   RST_I,
  input  logic                   STB_I,
  input  logic                   WE_I,
  input  logic [$clog2(NCH):0]   ADR_I,
  input  logic [MASK_BITS-1:0]   DAT_I,
  output logic [MASK_BITS-1:0]   DAT_O,
  output logic                   ACK_O,
  output logic                   o_alive,
  output logic [NCH-1:0]         o_led
);

  localparam int AW    = $clog2(NCH) + 1;
  localparam int CNT_W = $clog2(MASK_BITS + 1);

  // Channel-count constant one bit wider than the channel index so the
  // range compare below cannot overflow.
  localparam logic [AW:0]      NCH_L     = (AW + 1)'(NCH);
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(MASK_BITS);

  // ---------------------------------------------------------------------------
  // Shared divider. Free-running, never touched by the bus.
  // ---------------------------------------------------------------------------
  logic [SYSCLK_DIV_BITS-1:0] div_q;
  logic                       tick;

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      div_q <= '0;
    end else begin
      div_q <= div_q + 1'b1;
    end
  end

  assign tick    = &div_q;
  assign o_alive = div_q[SYSCLK_DIV_BITS-1];

  // ---------------------------------------------------------------------------
  // Bus decode
  // ---------------------------------------------------------------------------
  logic          access;
  logic [AW-1:0] chan_idx;
  logic          chan_ok;
  logic          is_ctrl;
  logic [NCH-1:0] mask_wr;
  logic [NCH-1:0] ctrl_wr;

  assign access   = STB_I & ~ACK_O;
  // Shifting the whole vector avoids an empty slice when NCH=1.
  assign chan_idx = ADR_I >> 1;
  assign chan_ok  = ({1'b0, chan_idx} < NCH_L);
  assign is_ctrl  = ADR_I[0];

  always_comb begin
    mask_wr = '0;
    ctrl_wr = '0;
    for (int n = 0; n < NCH; n++) begin
      if (access && WE_I && chan_ok && (chan_idx == AW'(n))) begin
        mask_wr[n] = ~is_ctrl;
        ctrl_wr[n] = is_ctrl;
      end
    end
  end

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      ACK_O <= 1'b0;
    end else begin
      ACK_O <= STB_I & ~ACK_O;
    end
  end

  // ---------------------------------------------------------------------------
  // Channel state
  // ---------------------------------------------------------------------------
  logic [MASK_BITS-1:0] pattern [NCH];
  logic [CNT_W-1:0]     cnt     [NCH];
  logic [NCH-1:0]       oneshot;

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      for (int n = 0; n < NCH; n++) begin
        pattern[n] <= '0;
        cnt[n]     <= '0;
      end
      oneshot <= '0;
      o_led   <= '0;
    end else begin
      for (int n = 0; n < NCH; n++) begin
        // A MASK write restarts the channel and wins over a coincident tick.
        if (mask_wr[n]) begin
          pattern[n] <= DAT_I;
          cnt[n]     <= CNT_RELOAD;
          o_led[n]   <= 1'b0;
        end else if (tick) begin
          if (!oneshot[n]) begin
            // REPEAT: rotate left, MSB wraps into bit 0.
            o_led[n]   <= pattern[n][MASK_BITS-1];
            pattern[n] <= {pattern[n][MASK_BITS-2:0], pattern[n][MASK_BITS-1]};
          end else if (cnt[n] != '0) begin
            // ONESHOT with bits left: shift left with zero fill.
            o_led[n]   <= pattern[n][MASK_BITS-1];
            pattern[n] <= {pattern[n][MASK_BITS-2:0], 1'b0};
            cnt[n]     <= cnt[n] - 1'b1;
          end else begin
            // ONESHOT finished: LED dark, state frozen.
            o_led[n] <= 1'b0;
          end
        end
        // The tick above used the old mode; the new mode applies from the
        // next tick. Pattern and counter are left alone (no restart), so
        // switching back to REPEAT rotates the partially zero-filled pattern.
        if (ctrl_wr[n]) begin
          oneshot[n] <= DAT_I[0];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read path
  // ---------------------------------------------------------------------------
`ifdef MULTIBLINKY_READBACK_EN
  logic [NCH-1:0]       done;
  logic [MASK_BITS-1:0] rd_data;

  always_comb begin
    for (int n = 0; n < NCH; n++) begin
      done[n] = oneshot[n] & (cnt[n] == '0);
    end
  end

  // Out-of-range channels read as zero.
  always_comb begin
    rd_data = '0;
    if (chan_ok) begin
      if (is_ctrl) begin
        rd_data[1:0] = {done[chan_idx], oneshot[chan_idx]};
      end else begin
        rd_data = pattern[chan_idx];
      end
    end
  end

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      DAT_O <= '0;
    end else if (access && !WE_I) begin
      DAT_O <= rd_data;
    end
  end
`else
  assign DAT_O = '0;
`endif

endmodule

// File: tb/tb_prewish5k_multiblinky.sv
// -----------------------------------------------------------------------------
// Testbench for prewish5k_multiblinky (NCH=4, MASK_BITS=8, SYSCLK_DIV_BITS=3).
// A reference model of the blinker runs alongside the DUT. Channel patterns
// are kept as plain integers and advanced with arithmetic (multiply/modulo),
// the divider as a cycle count modulo 8, and every cycle the DUT outputs are
// compared against the model with immediate assertions.
// -----------------------------------------------------------------------------
module tb_prewish5k_multiblinky;

  localparam int NCH = 4;
  localparam int MB  = 8;
  localparam int DB  = 3;
  localparam int PERIOD_TICKS = 1 << DB;

  logic          clk;
  logic          rst;
  logic          stb;
  logic          we;
  logic [2:0]    adr;
  logic [MB-1:0] dat_i;
  logic [MB-1:0] dat_o;
  logic          ack;
  logic          alive;
  logic [NCH-1:0] led;

  int errors;
  int checks;

  // Reference model state
  int div_m;
  bit ack_m;
  int dat_m;
  int p_m   [NCH];
  int rem_m [NCH];
  bit os_m  [NCH];
  bit led_m [NCH];

  prewish5k_multiblinky #(
    .NCH(NCH),
    .MASK_BITS(MB),
    .SYSCLK_DIV_BITS(DB)
  ) dut (
    .CLK_I(clk),
    .RST_I(rst),
    .STB_I(stb),
    .WE_I(we),
    .ADR_I(adr),
    .DAT_I(dat_i),
    .DAT_O(dat_o),
    .ACK_O(ack),
    .o_alive(alive),
    .o_led(led)
  );

  // ---------------------------------------------------------------------------
  // Clock
  // ---------------------------------------------------------------------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Checker
  // ---------------------------------------------------------------------------
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  task automatic model_reset();
    div_m = 0;
    ack_m = 1'b0;
    dat_m = 0;
    for (int n = 0; n < NCH; n++) begin
      p_m[n]   = 0;
      rem_m[n] = 0;
      os_m[n]  = 1'b0;
      led_m[n] = 1'b0;
    end
  endtask

  // Advance the model by one clock, using the inputs currently applied.
  task automatic model_step();
    bit acc;
    bit is_ctrl;
    bit tick;
    int ch;
    acc     = stb && !ack_m;
    ch      = int'(adr) / 2;
    is_ctrl = (int'(adr) % 2) == 1;
    tick    = (div_m == PERIOD_TICKS - 1);

    if (acc && !we) begin
`ifdef MULTIBLINKY_READBACK_EN
      if (ch < NCH) begin
        if (is_ctrl) begin
          dat_m = (os_m[ch] ? 1 : 0) + ((os_m[ch] && rem_m[ch] == 0) ? 2 : 0);
        end else begin
          dat_m = p_m[ch];
        end
      end else begin
        dat_m = 0;
      end
`else
      dat_m = 0;
`endif
    end

    for (int n = 0; n < NCH; n++) begin
      if (acc && we && !is_ctrl && ch == n) begin
        p_m[n]   = int'(dat_i);
        rem_m[n] = MB;
        led_m[n] = 1'b0;
      end else if (tick) begin
        if (!os_m[n]) begin
          led_m[n] = (p_m[n] / 128) != 0;
          p_m[n]   = (p_m[n] * 2) % 256 + p_m[n] / 128;
        end else if (rem_m[n] > 0) begin
          led_m[n] = (p_m[n] / 128) != 0;
          p_m[n]   = (p_m[n] * 2) % 256;
          rem_m[n] = rem_m[n] - 1;
        end else begin
          led_m[n] = 1'b0;
        end
      end
    end

    if (acc && we && is_ctrl && ch < NCH) os_m[ch] = dat_i[0];

    ack_m = stb && !ack_m;
    div_m = (div_m + 1) % PERIOD_TICKS;
  endtask

  task automatic check_outputs();
    logic [NCH-1:0] le;
    for (int n = 0; n < NCH; n++) le[n] = led_m[n];
    chk("led",   32'(led),   32'(le));
    chk("ack",   32'(ack),   32'(ack_m));
    chk("alive", 32'(alive), 32'(div_m >= PERIOD_TICKS / 2));
    chk("dat_o", 32'(dat_o), 32'(dat_m));
  endtask

  // ---------------------------------------------------------------------------
  // Drivers
  // ---------------------------------------------------------------------------
  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic do_write(input logic [2:0] a, input logic [MB-1:0] d);
    stb = 1'b1; we = 1'b1; adr = a; dat_i = d;
    step();
    stb = 1'b0; we = 1'b0;
    step();
  endtask

  // Leaves the bus one cycle after the access so the caller sees ACK high.
  task automatic start_read(input logic [2:0] a);
    stb = 1'b1; we = 1'b0; adr = a;
    step();
    stb = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1; stb = 1'b0; we = 1'b0; adr = '0; dat_i = '0;
    model_reset();

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_outputs();
    rst = 1'b0;
    step();

    // ch0 REPEAT 0xA0: 1,0,1,0,0,0,0,0 repeating
    do_write(3'b000, 8'hA0);
    repeat (20 * PERIOD_TICKS) step();

    // ch2 ONESHOT 0xC0: 1,1 then zeros, then stays dark; CTRL reads DONE|ONESHOT
    do_write(3'b101, 8'h01);
    do_write(3'b100, 8'hC0);
    repeat (10 * PERIOD_TICKS) step();
    start_read(3'b101);
`ifdef MULTIBLINKY_READBACK_EN
    chk("ctrl_rd_ch2", 32'(dat_o), 32'h03);
`endif
    chk("ctrl_rd_ack", 32'(ack), 32'h1);
    step();

    // ch0 REPEAT 0xF0; MASK write to ch1 lands exactly on a tick
    do_write(3'b000, 8'hF0);
    for (int k = 0; k < 2 * PERIOD_TICKS && div_m != PERIOD_TICKS - 1; k++) step();
    stb = 1'b1; we = 1'b1; adr = 3'b010; dat_i = 8'hFF;
    step();
    chk("tick_wr_ch1_led", 32'(led[1]), 32'h0);
    stb = 1'b0; we = 1'b0;
    repeat (4 * PERIOD_TICKS) step();

    // Held strobe: ACK 0,1,0,1 and two writes to ch3 CTRL
    stb = 1'b1; we = 1'b1; adr = 3'b111; dat_i = 8'h01;
    for (int i = 0; i < 4; i++) begin
      chk("held_stb_ack", 32'(ack), 32'(i % 2));
      step();
    end
    stb = 1'b0; we = 1'b0;
    do_write(3'b110, 8'h81);
    repeat (12 * PERIOD_TICKS) step();

    // Randomized traffic
    for (int it = 0; it < 250; it++) begin
      int hold;
      adr   = 3'($urandom_range(0, 7));
      dat_i = 8'($urandom_range(0, 255));
      we    = $urandom_range(0, 1) == 1;
      hold  = $urandom_range(1, 3);
      stb   = 1'b1;
      repeat (hold) step();
      stb = 1'b0;
      repeat ($urandom_range(0, 12)) step();
    end

    // Reset in the middle of a pattern and of an access
    do_write(3'b000, 8'hFF);
    repeat (2 * PERIOD_TICKS + 4) step();
    stb = 1'b1; we = 1'b1; adr = 3'b010; dat_i = 8'hAA;
    step();
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_led",   32'(led),   32'h0);
    chk("async_rst_ack",   32'(ack),   32'h0);
    chk("async_rst_alive", 32'(alive), 32'h0);
    model_reset();
    stb = 1'b0; we = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (6 * PERIOD_TICKS) step();

    // Read MASK ch0 after writing 0x5A
    do_write(3'b000, 8'h5A);
    start_read(3'b000);
`ifndef MULTIBLINKY_READBACK_EN
    chk("no_readback_dat", 32'(dat_o), 32'h0);
`endif
    chk("read_ack", 32'(ack), 32'h1);
    repeat (3) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
